// File: rtl/value_registers_pkg.sv
// Shared field widths and bit positions for the host-visible value registers.
package value_registers_pkg;

  localparam int STATUS_WIDTH = 16;
  localparam int ERROR_WIDTH  = 16;
  localparam int BYTE_WIDTH   = 8;
  localparam int OCC_WIDTH    = 7;

  localparam int STATUS_RX_DATA_READY = 0;
  localparam int STATUS_RX_ACTIVE     = 8;
  localparam int STATUS_TX_ACTIVE     = 9;

  localparam int ERROR_RX = 0;
  localparam int ERROR_TX = 8;

endpackage

// File: rtl/value_registers_reg.sv
// Plain D-to-Q register word with asynchronous active-low clear.
module value_reg
  import value_registers_pkg::*;
#(
  parameter int WIDTH = BYTE_WIDTH
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture the packed word every edge; reset clears it without waiting for clk.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/value_registers.sv
// Packs live status/error/occupancy/EHTS inputs into host-readable words,
// each held in its own register so every output comes straight from flops.
module value_registers
  import value_registers_pkg::*;
(
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    rxDataReady,
  input  logic                    rxTransferActive,
  input  logic                    txTransferActive,
  input  logic                    rxError,
  input  logic                    txError,
  input  logic [OCC_WIDTH-1:0]    bufferOccupancy,
  input  logic [BYTE_WIDTH-1:0]   nextEHTSData,
  output logic [STATUS_WIDTH-1:0] statusData,
  output logic [ERROR_WIDTH-1:0]  errorData,
  output logic [BYTE_WIDTH-1:0]   boData,
  output logic [BYTE_WIDTH-1:0]   ehtsData
);

  logic [STATUS_WIDTH-1:0] statusNext;
  logic [ERROR_WIDTH-1:0]  errorNext;
  logic [BYTE_WIDTH-1:0]   boNext;

  // Place each flag at its fixed bit; all unused bits stay zero.
  always_comb begin
    statusNext = '0;
    errorNext  = '0;
    statusNext[STATUS_RX_DATA_READY] = rxDataReady;
    statusNext[STATUS_RX_ACTIVE]     = rxTransferActive;
    statusNext[STATUS_TX_ACTIVE]     = txTransferActive;
    errorNext[ERROR_RX]              = rxError;
    errorNext[ERROR_TX]              = txError;
    boNext = {{(BYTE_WIDTH - OCC_WIDTH){1'b0}}, bufferOccupancy};
  end

  value_reg #(.WIDTH(STATUS_WIDTH)) statusReg (
    .clk (clk),
    .nRst(nRst),
    .d   (statusNext),
    .q   (statusData)
  );

  value_reg #(.WIDTH(ERROR_WIDTH)) errorReg (
    .clk (clk),
    .nRst(nRst),
    .d   (errorNext),
    .q   (errorData)
  );

  value_reg #(.WIDTH(BYTE_WIDTH)) boReg (
    .clk (clk),
    .nRst(nRst),
    .d   (boNext),
    .q   (boData)
  );

  value_reg #(.WIDTH(BYTE_WIDTH)) ehtsReg (
    .clk (clk),
    .nRst(nRst),
    .d   (nextEHTSData),
    .q   (ehtsData)
  );

endmodule

// File: tb/tb_value_registers.sv
// Self-checking bench for value_registers: vector table, hand sequences for
// reset corners, and random stimulus against an arithmetic reference model.
module tb_value_registers;

  typedef struct {
    logic       rdy;
    logic       rxAct;
    logic       txAct;
    logic       rxErr;
    logic       txErr;
    logic [6:0] occ;
    logic [7:0] ehts;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [15:0] expStatus;
    logic [15:0] expError;
    logic [7:0]  expBo;
    logic [7:0]  expEhts;
  } vec_t;

  typedef struct {
    int status;
    int error;
    int bo;
    int ehts;
  } expect_t;

  logic        tb_clk;
  logic        nRst;
  logic        rxDataReady;
  logic        rxTransferActive;
  logic        txTransferActive;
  logic        rxError;
  logic        txError;
  logic [6:0]  bufferOccupancy;
  logic [7:0]  nextEHTSData;
  logic [15:0] statusData;
  logic [15:0] errorData;
  logic [7:0]  boData;
  logic [7:0]  ehtsData;

  int passCount;
  int totalCount;

  value_registers dut (
    .clk             (tb_clk),
    .nRst            (nRst),
    .rxDataReady     (rxDataReady),
    .rxTransferActive(rxTransferActive),
    .txTransferActive(txTransferActive),
    .rxError         (rxError),
    .txError         (txError),
    .bufferOccupancy (bufferOccupancy),
    .nextEHTSData    (nextEHTSData),
    .statusData      (statusData),
    .errorData       (errorData),
    .boData          (boData),
    .ehtsData        (ehtsData)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Reference model: register words as weighted sums of the flags.
  function automatic expect_t model(input stim_t s);
    expect_t e;
    e.status = int'(s.rdy) * 1 + int'(s.rxAct) * 256 + int'(s.txAct) * 512;
    e.error  = int'(s.rxErr) * 1 + int'(s.txErr) * 256;
    e.bo     = int'(s.occ);
    e.ehts   = int'(s.ehts);
    return e;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) passCount++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkAll(input string tag, input int st, input int er, input int bo, input int eh);
    check({tag, ".status"}, int'(statusData), st);
    check({tag, ".error"},  int'(errorData),  er);
    check({tag, ".bo"},     int'(boData),     bo);
    check({tag, ".ehts"},   int'(ehtsData),   eh);
  endtask

  task automatic drive(input stim_t s);
    rxDataReady      = s.rdy;
    rxTransferActive = s.rxAct;
    txTransferActive = s.txAct;
    rxError          = s.rxErr;
    txError          = s.txErr;
    bufferOccupancy  = s.occ;
    nextEHTSData     = s.ehts;
  endtask

  // Drive at the falling edge, then sample 1 time unit after the rising edge.
  task automatic applyAndTick(input stim_t s);
    @(negedge tb_clk);
    drive(s);
    @(posedge tb_clk);
    #1;
  endtask

  function automatic stim_t mk(input logic rdy, input logic rxAct, input logic txAct,
                               input logic rxErr, input logic txErr,
                               input logic [6:0] occ, input logic [7:0] ehts);
    stim_t s;
    s.rdy = rdy; s.rxAct = rxAct; s.txAct = txAct;
    s.rxErr = rxErr; s.txErr = txErr; s.occ = occ; s.ehts = ehts;
    return s;
  endfunction

  vec_t    vecs[11];
  stim_t   cur;
  stim_t   prev;
  expect_t e;

  initial begin
    passCount  = 0;
    totalCount = 0;

    vecs[0]  = '{mk(1,0,1,0,0,7'h00,8'h00), 16'h0201, 16'h0000, 8'h00, 8'h00};
    vecs[1]  = '{mk(1,1,1,0,0,7'h00,8'h00), 16'h0301, 16'h0000, 8'h00, 8'h00};
    vecs[2]  = '{mk(0,0,0,1,0,7'h00,8'h00), 16'h0000, 16'h0001, 8'h00, 8'h00};
    vecs[3]  = '{mk(0,0,0,1,1,7'h00,8'h00), 16'h0000, 16'h0101, 8'h00, 8'h00};
    vecs[4]  = '{mk(0,0,0,0,0,7'h4F,8'h00), 16'h0000, 16'h0000, 8'h4F, 8'h00};
    vecs[5]  = '{mk(0,0,0,0,0,7'h7F,8'h00), 16'h0000, 16'h0000, 8'h7F, 8'h00};
    vecs[6]  = '{mk(0,0,0,0,0,7'h00,8'h00), 16'h0000, 16'h0000, 8'h00, 8'h00};
    vecs[7]  = '{mk(0,0,0,0,0,7'h00,8'h3A), 16'h0000, 16'h0000, 8'h00, 8'h3A};
    vecs[8]  = '{mk(0,0,0,0,0,7'h00,8'h12), 16'h0000, 16'h0000, 8'h00, 8'h12};
    vecs[9]  = '{mk(1,1,1,1,1,7'h7F,8'hFF), 16'h0301, 16'h0101, 8'h7F, 8'hFF};
    vecs[10] = '{mk(0,0,0,0,0,7'h00,8'h00), 16'h0000, 16'h0000, 8'h00, 8'h00};

    // Reset with every input high: outputs zero during and right after release.
    nRst = 1'b0;
    drive(mk(1,1,1,1,1,7'h7F,8'hFF));
    repeat (2) @(posedge tb_clk);
    #2;
    checkAll("rstHeld", 0, 0, 0, 0);
    @(negedge tb_clk);
    nRst = 1'b1;
    #1;
    checkAll("rstRelease", 0, 0, 0, 0);
    @(posedge tb_clk);
    #1;
    checkAll("firstEdge", 16'h0301, 16'h0101, 8'h7F, 8'hFF);

    for (int i = 0; i < 11; i++) begin
      applyAndTick(vecs[i].s);
      checkAll($sformatf("vec%0d", i), int'(vecs[i].expStatus), int'(vecs[i].expError),
               int'(vecs[i].expBo), int'(vecs[i].expEhts));
    end

    // Errors arriving one cycle apart leave the other words untouched.
    applyAndTick(mk(1,0,0,0,0,7'h20,8'h55));
    checkAll("errSeq0", 16'h0001, 16'h0000, 8'h20, 8'h55);
    applyAndTick(mk(1,0,0,1,0,7'h20,8'h55));
    checkAll("errSeq1", 16'h0001, 16'h0001, 8'h20, 8'h55);
    applyAndTick(mk(1,0,0,1,1,7'h20,8'h55));
    checkAll("errSeq2", 16'h0001, 16'h0101, 8'h20, 8'h55);

    // Mid-stream reset clears asynchronously; old values must not return.
    applyAndTick(mk(1,1,1,1,1,7'h4F,8'hA5));
    checkAll("preRst", 16'h0301, 16'h0101, 8'h4F, 8'hA5);
    #1;
    nRst = 1'b0;
    #1;
    checkAll("midRst", 0, 0, 0, 0);
    drive(mk(0,0,0,0,0,7'h00,8'h00));
    @(negedge tb_clk);
    nRst = 1'b1;
    #1;
    checkAll("midRstRelease", 0, 0, 0, 0);
    @(posedge tb_clk);
    #1;
    checkAll("postRstEdge", 0, 0, 0, 0);

    // Random stimulus: outputs hold the previous word until the edge, then follow.
    prev = mk(0,0,0,0,0,7'h00,8'h00);
    for (int n = 0; n < 200; n++) begin
      cur = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               7'($urandom), 8'($urandom));
      @(negedge tb_clk);
      drive(cur);
      #1;
      e = model(prev);
      if (n % 8 == 0) checkAll($sformatf("rndHold%0d", n), e.status, e.error, e.bo, e.ehts);
      @(posedge tb_clk);
      #1;
      e = model(cur);
      checkAll($sformatf("rnd%0d", n), e.status, e.error, e.bo, e.ehts);
      prev = cur;
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/value_registers.md
VALUE_REGISTERS -- requirements
Module: value_registers

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: nRst  input  1  asynchronous active-low reset.
REQ-004 Port: rxDataReady  input  1  received data available to host.
REQ-005 Port: rxTransferActive  input  1  USB receive transfer in progress.
REQ-006 Port: txTransferActive  input  1  USB transmit transfer in progress.
REQ-007 Port: rxError  input  1  receive error flag.
REQ-008 Port: txError  input  1  transmit error flag.
REQ-009 Port: bufferOccupancy  input  7  current data-buffer byte count (0-127).
REQ-010 Port: nextEHTSData  input  8  next endpoint/host-to-slave value to publish.
REQ-011 Port: statusData  output  16  registered status word.
REQ-012 Port: errorData  output  16  registered error word.
REQ-013 Port: boData  output  8  registered buffer-occupancy byte.
REQ-014 Port: ehtsData  output  8  registered EHTS byte.

Function
REQ-015 All four outputs SHALL come directly from flip-flops: each output equals its input mapping sampled at the previous rising clk edge (latency exactly 1 cycle).
REQ-016 statusData bit 0 SHALL equal registered rxDataReady.
REQ-017 statusData bit 8 SHALL equal registered rxTransferActive.
REQ-018 statusData bit 9 SHALL equal registered txTransferActive.
REQ-019 statusData bits 15:10, 7:1 SHALL always read 0.
REQ-020 errorData bit 0 SHALL equal registered rxError.
REQ-021 errorData bit 8 SHALL equal registered txError.
REQ-022 errorData bits 15:9, 7:1 SHALL always read 0.
REQ-023 Flags SHALL NOT be sticky: a flag deasserted at an edge reads 0 after that edge.
REQ-024 boData SHALL be {1'b0, bufferOccupancy}, i.e. zero-extended to 8 bits.
REQ-025 ehtsData SHALL equal nextEHTSData.
REQ-026 Simultaneous changes on any inputs SHALL all be captured at the same edge, with no priority or interaction between fields.
REQ-027 The block SHALL have no enables, no software write path and no other state.

Reset
REQ-028 While nRst=0, statusData, errorData, boData and ehtsData SHALL be 0 immediately, independent of clk.
REQ-029 On nRst release, outputs SHALL stay 0 until the first rising edge, then follow REQ-015.
REQ-030 Reset asserted mid-operation SHALL clear all outputs at once; previous values SHALL NOT reappear after release unless the inputs still present them.

Structure
REQ-031 A shared package SHALL hold the bit-position constants (STATUS_RX_DATA_READY=0, STATUS_RX_ACTIVE=8, STATUS_TX_ACTIVE=9, ERROR_RX=0, ERROR_TX=8) and field widths (16, 8, 7).
REQ-032 One parameterised sub-module, value_reg (WIDTH, async active-low clear, plain D-to-Q), SHALL be instantiated once per output word; the top level SHALL contain only bit packing.

Verification
REQ-033 Reset with all inputs high: all four outputs are 0 during reset and 0 at the first check after release, before any edge.
REQ-034 rxError=1, then txError=1 one cycle later: errorData=0x0001, then 0x0101 one edge later; statusData, boData and ehtsData unchanged.
REQ-035 rxDataReady=1, txTransferActive=1, rxTransferActive=0: statusData=0x0201 after one edge; with rxTransferActive also 1: 0x0301.
REQ-036 bufferOccupancy=0x4F: boData=0x4F after one edge; 0x7F gives 0x7F; 0x00 gives 0x00.
REQ-037 nextEHTSData=0x3A, then 0x12: ehtsData=0x3A, then 0x12, each one edge after the input changes.
REQ-038 All errors and flags set, then cleared: errorData and statusData return to 0x0000 one edge after clearing (non-sticky); nRst pulsed mid-stream clears all outputs asynchronously.
